// File: rtl/mouse_position_tracker.sv
// rtl/mouse_position_tracker.sv - PS/2 mouse packet assembler with DPI scaling, clamped X/Y and wheel accumulator.
// Packet bytes are collected by the FSM; UPD computes into a staging stage that commits one edge later.
module mouse_position_tracker #(
  parameter int MAX_X          = 160,
  parameter int MAX_Y          = 120,
  parameter int INIT_X         = 80,
  parameter int INIT_Y         = 60,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  input  logic       INTELLI_EN,
  input  logic [1:0] DPI,
  output logic [3:0] MouseStatus,
  output logic [7:0] MouseX,
  output logic [7:0] MouseY,
  output logic [7:0] MouseZ,
  output logic       SendInterrupt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_UPD} state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_btn;
  logic          r_xs, r_ys, r_xo, r_yo;
  logic          r_mode;
  logic [7:0]    r_dx, r_dy;
  logic [3:0]    r_z;
  logic [TW-1:0] r_tmo;

  logic          r_commit;
  logic [7:0]    r_new_x, r_new_y, r_new_z;
  logic [2:0]    r_new_btn;

  logic w_in_pkt;
  logic w_tmo_hit;

  assign w_in_pkt  = (r_state == S_B1) || (r_state == S_B2) || (r_state == S_B3);
  assign w_tmo_hit = w_in_pkt && !BYTE_VALID && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  function automatic logic signed [11:0] scale(input logic [8:0] d9, input logic ovf,
                                               input logic [1:0] dpi);
    logic signed [11:0] v;
    v = ovf ? 12'sd0 : {{3{d9[8]}}, d9};
    case (dpi)
      2'b00:   scale = v >>> 1;
      2'b01:   scale = v;
      2'b10:   scale = v <<< 1;
      default: scale = v <<< 2;
    endcase
  endfunction

  function automatic logic [7:0] clamp_add(input logic [7:0] pos, input logic signed [11:0] delta,
                                           input int max);
    logic signed [11:0] s;
    logic signed [11:0] lim;
    s   = $signed({4'b0000, pos}) + delta;
    lim = 12'(max - 1);
    if (s < 12'sd0)
      clamp_add = 8'd0;
    else if (s > lim)
      clamp_add = 8'(max - 1);
    else
      clamp_add = s[7:0];
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      r_state <= S_B0;
    else
      r_state <= w_next;
  end

  // Error beats a simultaneous valid byte; timeout only matters while mid-packet.
  always_comb begin
    w_next = r_state;
    if (BYTE_ERROR) begin
      w_next = S_B0;
    end else begin
      case (r_state)
        S_B0:  if (BYTE_VALID && BYTE_IN[3]) w_next = S_B1;
        S_B1:  if (BYTE_VALID) w_next = S_B2;
               else if (w_tmo_hit) w_next = S_B0;
        S_B2:  if (BYTE_VALID) w_next = r_mode ? S_B3 : S_UPD;
               else if (w_tmo_hit) w_next = S_B0;
        S_B3:  if (BYTE_VALID) w_next = S_UPD;
               else if (w_tmo_hit) w_next = S_B0;
        default: w_next = S_B0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_btn  <= '0;
      r_xs   <= 1'b0;
      r_ys   <= 1'b0;
      r_xo   <= 1'b0;
      r_yo   <= 1'b0;
      r_mode <= 1'b0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_z    <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_in_pkt && !BYTE_VALID && !BYTE_ERROR && !w_tmo_hit)
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;

      if (BYTE_VALID && !BYTE_ERROR) begin
        case (r_state)
          S_B0: if (BYTE_IN[3]) begin
            r_btn  <= BYTE_IN[2:0];
            r_xs   <= BYTE_IN[4];
            r_ys   <= BYTE_IN[5];
            r_xo   <= BYTE_IN[6];
            r_yo   <= BYTE_IN[7];
            r_mode <= INTELLI_EN;
          end
          S_B1: r_dx <= BYTE_IN;
          S_B2: r_dy <= BYTE_IN;
          S_B3: r_z  <= BYTE_IN[3:0];
          default: ;
        endcase
      end
    end
  end

  // Staging stage: values computed in UPD become visible on the following edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_commit  <= 1'b0;
      r_new_x   <= '0;
      r_new_y   <= '0;
      r_new_z   <= '0;
      r_new_btn <= '0;
    end else begin
      r_commit <= (r_state == S_UPD);
      if (r_state == S_UPD) begin
        r_new_x   <= clamp_add(MouseX, scale({r_xs, r_dx}, r_xo, DPI), MAX_X);
        r_new_y   <= clamp_add(MouseY, scale({r_ys, r_dy}, r_yo, DPI), MAX_Y);
        r_new_z   <= r_mode ? (MouseZ + {{4{r_z[3]}}, r_z}) : MouseZ;
        r_new_btn <= r_btn;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MouseX        <= 8'(INIT_X);
      MouseY        <= 8'(INIT_Y);
      MouseZ        <= '0;
      MouseStatus   <= '0;
      SendInterrupt <= 1'b0;
    end else begin
      SendInterrupt <= r_commit;
      if (r_commit) begin
        MouseX      <= r_new_x;
        MouseY      <= r_new_y;
        MouseZ      <= r_new_z;
        MouseStatus <= {1'b1, r_new_btn};
      end
    end
  end

endmodule
